// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: single-cycle ALU and address generation, plus a
// 32-cycle shift-add multiplier that stalls the front of the pipe while it runs.
module ex_mem_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] val1,
  input  logic [31:0] val2,
  input  logic [31:0] Simm,
  input  logic [3:0]  ALUCtrl,
  input  logic [4:0]  rd_addr,
  input  logic [1:0]  Mem,
  input  logic        WB,
  output logic [31:0] alu_result_o,
  output logic [31:0] store_data_o,
  output logic [4:0]  rd_addr_o,
  output logic [1:0]  Mem_o,
  output logic        WB_o,
  output logic        valid_o,
  output logic        stall_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 5;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b1111;

  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t          state;
  logic [DW-1:0]   mcand;
  logic [DW-1:0]   mplier;
  logic [DW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [4:0]      mul_rd;
  logic            mul_wb;

  logic [DW-1:0]   alu_res;
  logic [DW-1:0]   ex_result;
  logic [DW-1:0]   ex_store;
  logic [DW-1:0]   acc_sum;
  logic            is_mul;

  // Arithmetic/logic result, then memory-address override for loads/stores.
  always_comb begin
    alu_res   = '0;
    ex_result = '0;
    ex_store  = '0;
    unique case (ALUCtrl)
      OP_ADD:  alu_res = val1 + val2;
      OP_SUB:  alu_res = val1 - val2;
      OP_AND:  alu_res = val1 & val2;
      OP_OR:   alu_res = val1 | val2;
      default: alu_res = '0;
    endcase
    if (Mem[0]) begin
      ex_result = val1 + Simm;
      ex_store  = val2;
    end else if (Mem[1]) begin
      ex_result = val1 + val2;
    end else begin
      ex_result = alu_res;
    end
  end

  assign is_mul  = (ALUCtrl == OP_MUL);
  assign acc_sum = acc + (mplier[0] ? mcand : DW'(0));
  assign stall_o = (state == MUL);

  // State, multiplier datapath and EX/MEM output register; unwritten outputs default to a bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      cnt          <= '0;
      mul_rd       <= '0;
      mul_wb       <= 1'b0;
      alu_result_o <= '0;
      store_data_o <= '0;
      rd_addr_o    <= '0;
      Mem_o        <= '0;
      WB_o         <= 1'b0;
      valid_o      <= 1'b0;
    end else begin
      alu_result_o <= '0;
      store_data_o <= '0;
      rd_addr_o    <= '0;
      Mem_o        <= '0;
      WB_o         <= 1'b0;
      valid_o      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (valid_i && is_mul) begin
            mcand  <= val1;
            mplier <= val2;
            acc    <= '0;
            cnt    <= '0;
            mul_rd <= rd_addr;
            mul_wb <= WB;
            state  <= MUL;
          end else if (valid_i) begin
            alu_result_o <= ex_result;
            store_data_o <= ex_store;
            rd_addr_o    <= rd_addr;
            Mem_o        <= Mem;
            WB_o         <= WB && (rd_addr != 5'd0);
            valid_o      <= 1'b1;
          end
        end
        MUL: begin
          acc    <= acc_sum;
          mcand  <= {mcand[DW-2:0], 1'b0};
          mplier <= {1'b0, mplier[DW-1:1]};
          cnt    <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            alu_result_o <= acc_sum;
            rd_addr_o    <= mul_rd;
            WB_o         <= mul_wb && (mul_rd != 5'd0);
            valid_o      <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage: ALU ops, memory addressing,
// bubbles, multi-cycle multiply with stall, and reset abort.
module tb_ex_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] val1, val2, Simm;
  logic [3:0]  ALUCtrl;
  logic [4:0]  rd_addr;
  logic [1:0]  Mem;
  logic        WB;
  logic [31:0] alu_result_o, store_data_o;
  logic [4:0]  rd_addr_o;
  logic [1:0]  Mem_o;
  logic        WB_o, valid_o, stall_o;

  int errors = 0;
  int checks = 0;

  ex_mem_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
    .val1(val1), .val2(val2), .Simm(Simm), .ALUCtrl(ALUCtrl),
    .rd_addr(rd_addr), .Mem(Mem), .WB(WB),
    .alu_result_o(alu_result_o), .store_data_o(store_data_o),
    .rd_addr_o(rd_addr_o), .Mem_o(Mem_o), .WB_o(WB_o),
    .valid_o(valid_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] s, input logic [3:0] op, input logic [4:0] rd,
                       input logic [1:0] m, input logic w);
    valid_i = v; val1 = a; val2 = b; Simm = s;
    ALUCtrl = op; rd_addr = rd; Mem = m; WB = w;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] res, input logic [31:0] sd,
                         input logic [4:0] rd, input logic [1:0] m, input logic w,
                         input logic v);
    chk({tag, ".alu"},   alu_result_o, res);
    chk({tag, ".store"}, store_data_o, sd);
    chk({tag, ".rd"},    32'(rd_addr_o), 32'(rd));
    chk({tag, ".mem"},   32'(Mem_o), 32'(m));
    chk({tag, ".wb"},    32'(WB_o), 32'(w));
    chk({tag, ".valid"}, 32'(valid_o), 32'(v));
    chk({tag, ".stall"}, 32'(stall_o), 32'(0));
  endtask

  // Issue a mul in cycle N; expect 32 stall cycles of bubbles, result in N+33.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic w,
                         input logic [31:0] exp_res, input logic exp_wb);
    drive(1'b1, a, b, 32'h0, 4'b1111, rd, 2'b00, w);
    tick();
    // Junk instruction presented during MUL must be ignored.
    drive(1'b1, 32'h1234, 32'h1, 32'h0, 4'b0010, 5'd9, 2'b01, 1'b1);
    for (int k = 1; k <= 32; k++) begin
      chk({tag, ".stall_hi"}, 32'(stall_o), 32'(1));
      chk({tag, ".bubble_valid"}, 32'(valid_o), 32'(0));
      chk({tag, ".bubble_wb"}, 32'(WB_o), 32'(0));
      tick();
    end
    chk_out({tag, ".result"}, exp_res, 32'h0, rd, 2'b00, exp_wb, 1'b1);
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 4'b0000, 5'd0, 2'b00, 1'b0);
    tick();
    tick();
    chk_out("reset", 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0);
    rst_i = 1'b0;

    drive(1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0010, 5'd5, 2'b00, 1'b1);
    tick();
    chk_out("add_wrap", 32'h0, 32'h0, 5'd5, 2'b00, 1'b1, 1'b1);

    drive(1'b1, 32'd5, 32'd7, 32'h0, 4'b0110, 5'd6, 2'b00, 1'b1);
    tick();
    chk_out("sub", 32'hFFFF_FFFE, 32'h0, 5'd6, 2'b00, 1'b1, 1'b1);

    drive(1'b1, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 4'b0000, 5'd7, 2'b00, 1'b1);
    tick();
    chk_out("and", 32'h00F0_1200, 32'h0, 5'd7, 2'b00, 1'b1, 1'b1);

    drive(1'b1, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 4'b0001, 5'd8, 2'b00, 1'b0);
    tick();
    chk_out("or", 32'hFFF0_FF34, 32'h0, 5'd8, 2'b00, 1'b0, 1'b1);

    drive(1'b1, 32'h100, 32'hDEAD, 32'h0C, 4'b0110, 5'd0, 2'b01, 1'b0);
    tick();
    chk_out("store", 32'h10C, 32'hDEAD, 5'd0, 2'b01, 1'b0, 1'b1);

    drive(1'b1, 32'h200, 32'h24, 32'h999, 4'b0001, 5'd10, 2'b10, 1'b1);
    tick();
    chk_out("load", 32'h224, 32'h0, 5'd10, 2'b10, 1'b1, 1'b1);

    drive(1'b1, 32'h11, 32'h22, 32'h0, 4'b0011, 5'd12, 2'b00, 1'b1);
    tick();
    chk_out("unlisted", 32'h0, 32'h0, 5'd12, 2'b00, 1'b1, 1'b1);

    drive(1'b1, 32'h3, 32'h4, 32'h0, 4'b0010, 5'd0, 2'b00, 1'b1);
    tick();
    chk_out("add_rd0", 32'h7, 32'h0, 5'd0, 2'b00, 1'b0, 1'b1);

    drive(1'b0, 32'h3, 32'h4, 32'h8, 4'b0010, 5'd4, 2'b11, 1'b1);
    tick();
    chk_out("bubble", 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0);

    run_mul("mul7x6", 32'd7, 32'd6, 5'd3, 1'b1, 32'd42, 1'b1);
    run_mul("mul_wrap", 32'h8000_0000, 32'd3, 5'd4, 1'b1, 32'h8000_0000, 1'b1);
    run_mul("mul_zero", 32'd0, 32'd5, 5'd4, 1'b1, 32'd0, 1'b1);
    run_mul("mul_rd0", 32'd2, 32'd3, 5'd0, 1'b1, 32'd6, 1'b0);

    drive(1'b1, 32'd10, 32'd20, 32'h0, 4'b0010, 5'd11, 2'b00, 1'b1);
    tick();
    chk_out("after_mul", 32'd30, 32'h0, 5'd11, 2'b00, 1'b1, 1'b1);

    // Reset during cycle N+10 of a multiply.
    drive(1'b1, 32'd9, 32'd9, 32'h0, 4'b1111, 5'd13, 2'b00, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 4'b0000, 5'd0, 2'b00, 1'b0);
    for (int k = 1; k < 10; k++) tick();
    chk("rst_abort.stall_pre", 32'(stall_o), 32'(1));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk_out("rst_abort", 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      chk("rst_abort.no_product", 32'(valid_o), 32'(0));
      tick();
    end

    drive(1'b1, 32'd1, 32'd1, 32'h0, 4'b0010, 5'd2, 2'b00, 1'b1);
    tick();
    chk_out("post_reset_add", 32'd2, 32'h0, 5'd2, 2'b00, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have clk_i  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have rst_i  in  1  synchronous, active-high reset.
REQ-003 SHALL have valid_i  in  1  ID/EX slot holds a real instruction.
REQ-004 SHALL have val1  in  32  operand A from ID/EX.
REQ-005 SHALL have val2  in  32  operand B, rs2 data or I-immediate, from ID/EX.
REQ-006 SHALL have Simm  in  32  S-type immediate from ID/EX.
REQ-007 SHALL have ALUCtrl  in  4  0010 add, 0110 sub, 0000 and, 0001 or, 1111 mul.
REQ-008 SHALL have rd_addr  in  5  destination register.
REQ-009 SHALL have Mem  in  2  bit1 MemRead, bit0 MemWrite.
REQ-010 SHALL have WB  in  1  register write enable.
REQ-011 SHALL have alu_result_o  out  32  ALU result or memory address.
REQ-012 SHALL have store_data_o  out  32  data for store.
REQ-013 SHALL have rd_addr_o  out  5, Mem_o  out  2, WB_o  out  1, valid_o  out  1  registered EX/MEM controls.
REQ-014 SHALL have stall_o  out  1  freeze PC, IF/ID and ID/EX while high.

Function
REQ-015 SHALL register all outputs except stall_o; non-mul latency is 1 cycle (inputs in cycle N, outputs valid in cycle N+1).
REQ-016 SHALL compute add/sub modulo 2^32 (wrap, no flags), and/or bitwise, from val1, val2.
REQ-017 SHALL, when Mem[0]=1, output alu_result_o = val1 + Simm (mod 2^32) and store_data_o = val2, regardless of ALUCtrl.
REQ-018 SHALL, when Mem[1]=1 and Mem[0]=0, output alu_result_o = val1 + val2.
REQ-019 SHALL output store_data_o = 0 when Mem[0]=0.
REQ-020 SHALL output alu_result_o = 0 for unlisted ALUCtrl codes, controls passed unchanged.
REQ-021 SHALL force WB_o = 0 whenever rd_addr = 0.
REQ-022 SHALL, when valid_i=0 in IDLE, emit a bubble: valid_o=0, WB_o=0, Mem_o=00, rd_addr_o=0, alu_result_o=0, store_data_o=0.
REQ-023 SHALL implement FSM states IDLE and MUL; IDLE is the reset state.
REQ-024 SHALL, in IDLE with valid_i=1 and ALUCtrl=1111 in cycle N, latch val1 (multiplicand), val2 (multiplier), rd_addr, WB into internal registers, clear accumulator and 5-bit counter, emit a bubble, and enter MUL.
REQ-025 SHALL, each MUL cycle, add multiplicand to accumulator if multiplier bit0=1, shift multiplicand left 1, shift multiplier right 1, increment counter.
REQ-026 SHALL take exactly 32 MUL cycles (N+1..N+32) independent of operand values, including zero operands.
REQ-027 SHALL, at the edge ending cycle N+32 (counter 31), write low 32 bits of product to alu_result_o with valid_o=1, Mem_o=00, store_data_o=0, latched rd/WB (REQ-021 applies), and return to IDLE.
REQ-028 SHALL emit bubbles on the edges ending cycles N+1..N+31.
REQ-029 SHALL drive stall_o = 1 combinationally exactly while state = MUL (cycles N+1..N+32); 0 in IDLE.
REQ-030 SHALL ignore all inputs while in MUL; the instruction presented in cycle N+33 is processed normally, including a back-to-back mul.
REQ-031 SHALL ignore Mem for mul (Mem_o forced 00).

Reset
REQ-032 SHALL, on rst_i=1 at a rising edge, set state IDLE, counter 0, accumulator 0, all registered outputs 0; stall_o = 0 the following cycle.
REQ-033 SHALL abort an in-flight multiply on reset with no result emitted; rst_i takes priority over every other event.

Verification
REQ-034 add: val1=0xFFFFFFFF, val2=1, ALUCtrl=0010, rd=5, WB=1 -> next cycle alu_result_o=0, WB_o=1, rd_addr_o=5, valid_o=1.
REQ-035 store: Mem=01, val1=0x100, Simm=0x0C, val2=0xDEAD -> alu_result_o=0x10C, store_data_o=0xDEAD, Mem_o=01.
REQ-036 mul: val1=7, val2=6, rd=3 in cycle N -> stall_o high N+1..N+32, bubbles meanwhile, cycle N+33 alu_result_o=42, valid_o=1, stall_o=0.
REQ-037 mul wrap: val1=0x80000000, val2=3 -> alu_result_o=0x80000000 after 32 stall cycles; back-to-back mul 0*5 -> 0 after another 32.
REQ-038 reset at cycle N+10 of a mul -> stall_o=0 next cycle, all outputs 0, no product ever emitted.
REQ-039 rd=0 with WB=1 (add and mul) -> WB_o=0, valid_o=1.
